alu_issue_queue: RTL and testbench
==================================

# alu_issue_queue

Age-ordered reservation station that feeds operands and an operation code to the integer ALU. Decode/rename dispatches ALU ops into it; it captures results broadcast on the common data bus (CDB) to wake up waiting source operands. Each cycle it offers the oldest fully ready entry to the ALU stage on a valid/ready handshake. The queue sits between rename/dispatch and the ALU execute stage, one instance per ALU pipe.

## Interface
- DEPTH, 4: number of entries (≥2).
- TAG_W, 5: destination/source tag width.
- XLEN, 32: operand width.

- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept; equals count < DEPTH.
- disp_alu_control  in  4  ALU opcode, passed through unmodified.
- disp_add_sub_mode  in  1  adder mode, 0 = add, 1 = sub.
- disp_src1_rdy, disp_src2_rdy  in  1 each  operand value already valid.
- disp_src1_val, disp_src2_val  in  XLEN each  operand value when rdy=1.
- disp_src1_tag, disp_src2_tag  in  TAG_W each  producer tag when rdy=0.
- disp_dst_tag  in  TAG_W  destination tag of this op.
- cdb_valid  in  1  result broadcast valid.
- cdb_tag  in  TAG_W  tag of broadcast result.
- cdb_value  in  XLEN  broadcast result.
- iss_valid  out  1  selected entry offered to ALU.
- iss_ready  in  1  ALU stage accepts.
- iss_A, iss_B  out  XLEN each  src1/src2 operand values.
- iss_alu_control  out  4  opcode of selected entry.
- iss_add_sub_mode  out  1  adder mode of selected entry.
- iss_dst_tag  out  TAG_W  destination tag of selected entry.
- count  out  $clog2(DEPTH+1)  number of valid entries.

## Operation
- Entries held in age order: slot 0 oldest, slots 0..count-1 valid, no holes.
- Per entry: opcode, add_sub_mode, dst_tag, per-source {rdy, tag, val}.
- disp_fire = disp_valid & disp_ready & ~flush. iss_fire = iss_valid & iss_ready.
- Select: lowest-index valid entry with both sources rdy. iss_valid = any such entry & ~flush. iss_* are combinational from the selected entry; all iss_* data are 0 when iss_valid=0.
- On iss_fire of slot k: slots k+1..count-1 shift down one; the new dispatch (if any) is written to slot count-iss_fire.
- Wakeup: each cycle, every stored source with rdy=0 and tag==cdb_tag while cdb_valid=1 sets rdy=1 and captures cdb_value. This applies to entries in their post-shift position.
- Dispatch bypass: a dispatching source with rdy=0 whose tag matches a same-cycle valid CDB is written with rdy=1 and val=cdb_value.
- count_next = count + disp_fire − iss_fire.
- flush: all entries invalid, count=0 at the edge. Dispatch in the flush cycle is dropped and iss_valid=0.
- Full: disp_ready=0 even if an issue fires the same cycle. No same-cycle refill.
- Tags are not interpreted beyond equality. An issued entry is not woken.

## Timing
- Reset (rst_n low, asynchronous): count=0, all entries invalid, iss_valid=0, all iss_* data 0, disp_ready=1. Release is synchronous to clk.
- Dispatch-to-issue minimum latency: 1 cycle. An op dispatched with both sources ready at edge E drives iss_valid in the cycle after E.
- Wakeup-to-issue: 1 cycle. A CDB match at edge E makes the entry eligible in the cycle after E.
- iss_valid and iss_* may change while iss_ready=0, since an older entry may become ready. This does not follow the sticky-valid convention; the ALU stage samples only on iss_fire.
- Throughput: one issue and one dispatch per cycle.

## Test plan
- Reset and idle: assert rst_n=0 mid-operation with 3 entries. Required: count=0, iss_valid=0 and disp_ready=1 immediately, without waiting for a clock edge.
- Ready dispatch: dispatch ADD (0000), mode 0, src1=5, src2=7, dst=3, both ready, iss_ready=1. Required: next cycle iss_valid=1, iss_A=5, iss_B=7, iss_dst_tag=3; the cycle after, count=0.
- Wakeup and ordering: dispatch A (src2 waits tag 9), then B (both ready). Required: B issues first. Then cdb_valid, tag 9, value 0xDEADBEEF. Required: next cycle A issues with iss_B=0xDEADBEEF.
- Dispatch bypass: dispatch an op with src1 tag 4 not ready, same cycle as CDB tag 4 value 0x10. Required: the op issues next cycle with iss_A=0x10.
- Full and backpressure: with iss_ready=0, dispatch DEPTH ready ops. Required: disp_ready=0 and count=DEPTH. Then iss_ready=1 for DEPTH cycles. Required: ops issue in dispatch order, disp_ready returns 1 after the first issue, and count reaches 0.
- Flush: with 3 entries and a concurrent disp_valid, pulse flush. Required: iss_valid=0 that cycle, count=0 next cycle, and the dispatched op is never issued.

Source files
------------

// File: rtl/alu_issue_queue.sv
// Age-ordered ALU reservation station: captures CDB results, offers the oldest
// fully ready entry to the ALU, and compacts the queue on every issue.
module alu_issue_queue #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 5,
   parameter int XLEN  = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         disp_valid,
   output logic                         disp_ready,
   input  logic [3:0]                   disp_alu_control,
   input  logic                         disp_add_sub_mode,
   input  logic                         disp_src1_rdy,
   input  logic                         disp_src2_rdy,
   input  logic [XLEN-1:0]              disp_src1_val,
   input  logic [XLEN-1:0]              disp_src2_val,
   input  logic [TAG_W-1:0]             disp_src1_tag,
   input  logic [TAG_W-1:0]             disp_src2_tag,
   input  logic [TAG_W-1:0]             disp_dst_tag,
   input  logic                         cdb_valid,
   input  logic [TAG_W-1:0]             cdb_tag,
   input  logic [XLEN-1:0]              cdb_value,
   output logic                         iss_valid,
   input  logic                         iss_ready,
   output logic [XLEN-1:0]              iss_A,
   output logic [XLEN-1:0]              iss_B,
   output logic [3:0]                   iss_alu_control,
   output logic                         iss_add_sub_mode,
   output logic [TAG_W-1:0]             iss_dst_tag,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(DEPTH);

   typedef struct packed {
      logic [3:0]       alu_control;
      logic             add_sub_mode;
      logic [TAG_W-1:0] dst_tag;
      logic             src1_rdy;
      logic [TAG_W-1:0] src1_tag;
      logic [XLEN-1:0]  src1_val;
      logic             src2_rdy;
      logic [TAG_W-1:0] src2_tag;
      logic [XLEN-1:0]  src2_val;
   } entry_t;

   entry_t          ent_q [DEPTH];
   entry_t          ent_d [DEPTH];
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   count_d;

   logic [DEPTH-1:0] eligible;
   logic             found;
   logic [IW-1:0]    sel_idx;
   logic             disp_fire;
   logic             iss_fire;
   logic [CW-1:0]    wr_idx;
   entry_t           new_ent;

   // An entry is eligible when it is live and both operands are captured.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < DEPTH; i++) begin
         eligible[i] = (CW'(i) < count_q) && ent_q[i].src1_rdy && ent_q[i].src2_rdy;
      end
   end

   always_comb begin
      found   = 1'b0;
      sel_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            found   = 1'b1;
            sel_idx = IW'(i);
         end
      end
   end

   assign count      = count_q;
   assign disp_ready = (count_q < CW'(DEPTH));
   assign iss_valid  = found & ~flush;
   assign disp_fire  = disp_valid & disp_ready & ~flush;
   assign iss_fire   = iss_valid & iss_ready;
   assign wr_idx     = count_q - CW'(iss_fire);

   always_comb begin
      iss_A            = '0;
      iss_B            = '0;
      iss_alu_control  = '0;
      iss_add_sub_mode = 1'b0;
      iss_dst_tag      = '0;
      if (iss_valid) begin
         iss_A            = ent_q[sel_idx].src1_val;
         iss_B            = ent_q[sel_idx].src2_val;
         iss_alu_control  = ent_q[sel_idx].alu_control;
         iss_add_sub_mode = ent_q[sel_idx].add_sub_mode;
         iss_dst_tag      = ent_q[sel_idx].dst_tag;
      end
   end

   // Incoming op, with a same-cycle CDB result forwarded into waiting sources.
   always_comb begin
      new_ent.alu_control  = disp_alu_control;
      new_ent.add_sub_mode = disp_add_sub_mode;
      new_ent.dst_tag      = disp_dst_tag;
      new_ent.src1_rdy     = disp_src1_rdy;
      new_ent.src1_tag     = disp_src1_tag;
      new_ent.src1_val     = disp_src1_val;
      new_ent.src2_rdy     = disp_src2_rdy;
      new_ent.src2_tag     = disp_src2_tag;
      new_ent.src2_val     = disp_src2_val;
      if (!disp_src1_rdy && cdb_valid && (disp_src1_tag == cdb_tag)) begin
         new_ent.src1_rdy = 1'b1;
         new_ent.src1_val = cdb_value;
      end
      if (!disp_src2_rdy && cdb_valid && (disp_src2_tag == cdb_tag)) begin
         new_ent.src2_rdy = 1'b1;
         new_ent.src2_val = cdb_value;
      end
   end

   // Compact over the issued slot, append the dispatch, then wake up survivors.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = ent_q[i];
      end
      for (int i = 0; i < DEPTH - 1; i++) begin
         if (iss_fire && (IW'(i) >= sel_idx)) begin
            ent_d[i] = ent_q[i + 1];
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (disp_fire && (CW'(i) == wr_idx)) begin
            ent_d[i] = new_ent;
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (cdb_valid && !ent_d[i].src1_rdy && (ent_d[i].src1_tag == cdb_tag)) begin
            ent_d[i].src1_rdy = 1'b1;
            ent_d[i].src1_val = cdb_value;
         end
         if (cdb_valid && !ent_d[i].src2_rdy && (ent_d[i].src2_tag == cdb_tag)) begin
            ent_d[i].src2_rdy = 1'b1;
            ent_d[i].src2_val = cdb_value;
         end
      end
      if (flush) begin
         count_d = '0;
      end else begin
         count_d = count_q + CW'(disp_fire) - CW'(iss_fire);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed self-checking bench for alu_issue_queue (DEPTH=4, TAG_W=5, XLEN=32).
module tb_alu_issue_queue;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        disp_valid;
   logic        disp_ready;
   logic [3:0]  disp_alu_control;
   logic        disp_add_sub_mode;
   logic        disp_src1_rdy;
   logic        disp_src2_rdy;
   logic [31:0] disp_src1_val;
   logic [31:0] disp_src2_val;
   logic [4:0]  disp_src1_tag;
   logic [4:0]  disp_src2_tag;
   logic [4:0]  disp_dst_tag;
   logic        cdb_valid;
   logic [4:0]  cdb_tag;
   logic [31:0] cdb_value;
   logic        iss_valid;
   logic        iss_ready;
   logic [31:0] iss_A;
   logic [31:0] iss_B;
   logic [3:0]  iss_alu_control;
   logic        iss_add_sub_mode;
   logic [4:0]  iss_dst_tag;
   logic [2:0]  count;

   int passCount;
   int totalChecks;

   alu_issue_queue #(.DEPTH(4), .TAG_W(5), .XLEN(32)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .flush             (flush),
      .disp_valid        (disp_valid),
      .disp_ready        (disp_ready),
      .disp_alu_control  (disp_alu_control),
      .disp_add_sub_mode (disp_add_sub_mode),
      .disp_src1_rdy     (disp_src1_rdy),
      .disp_src2_rdy     (disp_src2_rdy),
      .disp_src1_val     (disp_src1_val),
      .disp_src2_val     (disp_src2_val),
      .disp_src1_tag     (disp_src1_tag),
      .disp_src2_tag     (disp_src2_tag),
      .disp_dst_tag      (disp_dst_tag),
      .cdb_valid         (cdb_valid),
      .cdb_tag           (cdb_tag),
      .cdb_value         (cdb_value),
      .iss_valid         (iss_valid),
      .iss_ready         (iss_ready),
      .iss_A             (iss_A),
      .iss_B             (iss_B),
      .iss_alu_control   (iss_alu_control),
      .iss_add_sub_mode  (iss_add_sub_mode),
      .iss_dst_tag       (iss_dst_tag),
      .count             (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic applyStimulus(input logic dv, input logic [3:0] op, input logic mode,
                                input logic r1, input logic [31:0] v1, input logic [4:0] t1,
                                input logic r2, input logic [31:0] v2, input logic [4:0] t2,
                                input logic [4:0] dst);
      disp_valid        = dv;
      disp_alu_control  = op;
      disp_add_sub_mode = mode;
      disp_src1_rdy     = r1;
      disp_src1_val     = v1;
      disp_src1_tag     = t1;
      disp_src2_rdy     = r2;
      disp_src2_val     = v2;
      disp_src2_tag     = t2;
      disp_dst_tag      = dst;
   endtask

   task automatic idleDispatch();
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 5'd0);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      totalChecks++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
   endtask

   initial begin
      passCount   = 0;
      totalChecks = 0;
      rst_n       = 1'b0;
      flush       = 1'b0;
      iss_ready   = 1'b0;
      cdb_valid   = 1'b0;
      cdb_tag     = 5'd0;
      cdb_value   = 32'h0;
      idleDispatch();

      // Power-on reset state
      @(negedge clk);
      checkOutput("reset_count", 32'(count), 32'd0);
      checkOutput("reset_iss_valid", 32'(iss_valid), 32'd0);
      checkOutput("reset_disp_ready", 32'(disp_ready), 32'd1);
      rst_n = 1'b1;

      // Ready dispatch: ADD 5,7 -> tag 3
      @(negedge clk);
      iss_ready = 1'b1;
      applyStimulus(1'b1, 4'h0, 1'b0, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0, 5'd3);
      #1 checkOutput("disp_iss_valid_same_cycle", 32'(iss_valid), 32'd0);
      @(negedge clk);
      idleDispatch();
      #1;
      checkOutput("ready_iss_valid", 32'(iss_valid), 32'd1);
      checkOutput("ready_iss_A", iss_A, 32'd5);
      checkOutput("ready_iss_B", iss_B, 32'd7);
      checkOutput("ready_iss_dst", 32'(iss_dst_tag), 32'd3);
      checkOutput("ready_count", 32'(count), 32'd1);
      @(negedge clk);
      #1;
      checkOutput("ready_count_after", 32'(count), 32'd0);
      checkOutput("idle_iss_valid", 32'(iss_valid), 32'd0);
      checkOutput("idle_iss_A_zero", iss_A, 32'd0);

      // Wakeup and ordering: A waits on tag 9, younger B is ready
      @(negedge clk);
      applyStimulus(1'b1, 4'h1, 1'b1, 1'b1, 32'h11, 5'd0, 1'b0, 32'h0, 5'd9, 5'd5);
      @(negedge clk);
      applyStimulus(1'b1, 4'h2, 1'b0, 1'b1, 32'd1, 5'd0, 1'b1, 32'd2, 5'd0, 5'd6);
      #1 checkOutput("wait_iss_valid", 32'(iss_valid), 32'd0);
      @(negedge clk);
      idleDispatch();
      #1;
      checkOutput("order_B_first_valid", 32'(iss_valid), 32'd1);
      checkOutput("order_B_first_dst", 32'(iss_dst_tag), 32'd6);
      checkOutput("order_count", 32'(count), 32'd2);
      @(negedge clk);
      cdb_valid = 1'b1;
      cdb_tag   = 5'd9;
      cdb_value = 32'hDEADBEEF;
      #1;
      checkOutput("wakeup_pre_valid", 32'(iss_valid), 32'd0);
      checkOutput("wakeup_pre_count", 32'(count), 32'd1);
      @(negedge clk);
      cdb_valid = 1'b0;
      #1;
      checkOutput("wakeup_iss_valid", 32'(iss_valid), 32'd1);
      checkOutput("wakeup_iss_B", iss_B, 32'hDEADBEEF);
      checkOutput("wakeup_iss_A", iss_A, 32'h11);
      checkOutput("wakeup_iss_dst", 32'(iss_dst_tag), 32'd5);
      checkOutput("wakeup_iss_op", 32'(iss_alu_control), 32'h1);
      checkOutput("wakeup_iss_mode", 32'(iss_add_sub_mode), 32'd1);
      @(negedge clk);
      #1 checkOutput("wakeup_count_after", 32'(count), 32'd0);

      // Dispatch bypass: src1 tag 4 resolved by the same-cycle CDB
      applyStimulus(1'b1, 4'h3, 1'b0, 1'b0, 32'h0, 5'd4, 1'b1, 32'd2, 5'd0, 5'd7);
      cdb_valid = 1'b1;
      cdb_tag   = 5'd4;
      cdb_value = 32'h10;
      @(negedge clk);
      idleDispatch();
      cdb_valid = 1'b0;
      #1;
      checkOutput("bypass_iss_valid", 32'(iss_valid), 32'd1);
      checkOutput("bypass_iss_A", iss_A, 32'h10);
      checkOutput("bypass_iss_dst", 32'(iss_dst_tag), 32'd7);
      @(negedge clk);
      #1 checkOutput("bypass_count_after", 32'(count), 32'd0);

      // Full and backpressure: four ready ops dst 10..13 with iss_ready low
      iss_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 4'(i + 4), 1'b0, 1'b1, 32'(100 + i), 5'd0, 1'b1, 32'(200 + i), 5'd0, 5'(10 + i));
         @(negedge clk);
      end
      // Dispatch held high while full and issuing must be refused
      applyStimulus(1'b1, 4'hF, 1'b0, 1'b1, 32'h0, 5'd0, 1'b1, 32'h0, 5'd0, 5'd20);
      iss_ready = 1'b1;
      #1;
      checkOutput("full_count", 32'(count), 32'd4);
      checkOutput("full_disp_ready", 32'(disp_ready), 32'd0);
      checkOutput("full_issue0_dst", 32'(iss_dst_tag), 32'd10);
      checkOutput("full_issue0_A", iss_A, 32'd100);
      @(negedge clk);
      idleDispatch();
      #1;
      checkOutput("drain_disp_ready", 32'(disp_ready), 32'd1);
      checkOutput("drain1_count", 32'(count), 32'd3);
      checkOutput("drain1_dst", 32'(iss_dst_tag), 32'd11);
      checkOutput("drain1_op", 32'(iss_alu_control), 32'h5);
      @(negedge clk);
      #1;
      checkOutput("drain2_dst", 32'(iss_dst_tag), 32'd12);
      checkOutput("drain2_B", iss_B, 32'd202);
      @(negedge clk);
      #1;
      checkOutput("drain3_dst", 32'(iss_dst_tag), 32'd13);
      checkOutput("drain3_count", 32'(count), 32'd1);
      @(negedge clk);
      #1;
      checkOutput("drain_count_zero", 32'(count), 32'd0);
      checkOutput("drain_no_refill", 32'(iss_valid), 32'd0);

      // Flush with three entries and a concurrent dispatch
      iss_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 4'h0, 1'b0, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0, 5'(15 + i));
         @(negedge clk);
      end
      applyStimulus(1'b1, 4'h0, 1'b0, 1'b1, 32'd9, 5'd0, 1'b1, 32'd9, 5'd0, 5'd25);
      flush = 1'b1;
      #1;
      checkOutput("flush_pre_count", 32'(count), 32'd3);
      checkOutput("flush_iss_valid", 32'(iss_valid), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      idleDispatch();
      iss_ready = 1'b1;
      #1;
      checkOutput("flush_count", 32'(count), 32'd0);
      checkOutput("flush_dropped_dispatch", 32'(iss_valid), 32'd0);
      @(negedge clk);
      #1 checkOutput("flush_still_empty", 32'(iss_valid), 32'd0);

      // Asynchronous reset in the middle of operation
      iss_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 4'h0, 1'b0, 1'b1, 32'd3, 5'd0, 1'b1, 32'd4, 5'd0, 5'(1 + i));
         @(negedge clk);
      end
      idleDispatch();
      #1 checkOutput("mid_count", 32'(count), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_reset_count", 32'(count), 32'd0);
      checkOutput("async_reset_iss_valid", 32'(iss_valid), 32'd0);
      checkOutput("async_reset_disp_ready", 32'(disp_ready), 32'd1);
      checkOutput("async_reset_iss_A", iss_A, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("%0d/%0d checks passed", passCount, totalChecks);
      $finish;
   end

endmodule
